// File: rtl/serial_twos_ctrl_pkg.sv
// Shared definitions for the bit-serial negate / absolute-value unit:
// default sizing, FSM state encoding and the overflow rule.
package serial_twos_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A result is unrepresentable only when the most-negative value was
    // inverted: the operand MSB was set and the result MSB is still set.
    function automatic logic calc_ovf(input logic inv, input logic msb, input logic res_msb);
        return inv & msb & res_msb;
    endfunction

endpackage

// File: rtl/serial_twos_ctrl_full_adder.sv
// Single-bit full adder; the one datapath cell shared across all bit positions.
module serial_twos_ctrl_full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Cout
);

    assign Y    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_twos_ctrl.sv
// Bit-serial two's-complement negate / absolute value.
// One operand bit per cycle (LSB first) passes through a single full adder,
// the carry is kept in a flip-flop, and the result is assembled in a shift
// register. Operands and results move on valid/ready handshakes.
module serial_twos_ctrl
    import serial_twos_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_abs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               inv_q;
    logic               msb_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_ovf_q;

    logic               accept;
    logic               last_bit;
    logic               in_inv;
    logic               fa_a;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_next;

    // Negate always inverts; abs inverts only negative operands.
    assign in_inv   = in_abs ? in_data[WIDTH-1] : 1'b1;
    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Invert-and-add-one done serially: the +1 enters as the initial carry.
    assign fa_a     = opnd_q[0] ^ inv_q;
    assign res_next = {fa_sum, res_q[WIDTH-1:1]};

    serial_twos_ctrl_full_adder u_full_adder (
        .A    (fa_a),
        .B    (1'b0),
        .Cin  (carry_q),
        .Y    (fa_sum),
        .Cout (fa_cout)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs, decoded from the current state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    // Datapath: capture on accept, shift one bit per SHIFT cycle, and latch
    // the finished result into the output registers on the last bit so the
    // outputs stay put while the next operation shifts.
    // NOTE: every datapath register is cleared on reset so an aborted
    // operation leaves nothing visible on out_data / out_ovf.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            inv_q      <= 1'b0;
            msb_q      <= 1'b0;
            opnd_q     <= '0;
            res_q      <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else if (accept) begin
            opnd_q  <= in_data;
            cnt_q   <= '0;
            inv_q   <= in_inv;
            carry_q <= in_inv;
            msb_q   <= in_data[WIDTH-1];
        end else if (state_q == ST_SHIFT) begin
            res_q   <= res_next;
            opnd_q  <= opnd_q >> 1;
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                out_data_q <= res_next;
                out_ovf_q  <= calc_ovf(inv_q, msb_q, fa_sum);
            end
        end
    end

    assign out_data = out_data_q;
    assign out_ovf  = out_ovf_q;

endmodule

// File: doc/serial_twos_ctrl.md
Name: serial_twos_ctrl

Overview:
- Bit-serial negate / absolute-value unit built around a single shared full_adder cell, in place of an 8-instance ripple chain.
- An FSM feeds one operand bit per cycle, LSB first, through the adder and keeps the carry in a flip-flop.
- Operands enter and results leave on valid/ready handshakes, so the block can sit between a register file and the ALU result bus.
- Trades latency (WIDTH+1 cycles) for area (one adder cell).

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2)
- CNT_W, 3, bit counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand present
- in_ready  output  1  block accepts an operand this cycle
- in_data  input  WIDTH  operand, two's complement
- in_abs  input  1  0 = negate; 1 = absolute value
- out_valid  output  1  result present
- out_ready  input  1  consumer takes the result this cycle
- out_data  output  WIDTH  result
- out_ovf  output  1  result not representable (input = most-negative value and inversion applied)
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Interface: single clock clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset: on any edge with rst_n=0:
  - state <= IDLE; counter, carry, operand and result registers <= 0.
  - out_valid=0, out_data=0, out_ovf=0, busy=0, in_ready=1 from that edge on.
  - Reset overrides every other event, including mid-SHIFT and a DONE awaiting out_ready; the in-flight operation is discarded and no output is produced.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - in_ready=1. The input handshake completes on an edge where in_valid & in_ready.
  - On that edge: opnd <= in_data; cnt <= 0; carry <= inv; state <= SHIFT.
  - inv = in_abs ? in_data[WIDTH-1] : 1, latched as a register.
- SHIFT:
  - in_ready=0.
  - Adder inputs each cycle: A = opnd[0] ^ inv, B = 0, Cin = carry.
  - On each edge: res <= {sum, res[WIDTH-1:1]}; opnd <= opnd >> 1; carry <= Cout; cnt <= cnt+1.
  - The original MSB is saved in msb_q at accept.
  - On the edge where cnt == WIDTH-1: state <= DONE.
  - The final Cout is discarded; the result is modulo 2**WIDTH.
- DONE:
  - out_valid=1; out_data=res; out_ovf = inv & msb_q & res[WIDTH-1].
  - Outputs hold stable while out_ready=0.
  - On an edge with out_ready=1: state <= IDLE, out_valid <= 0.
  - in_valid is ignored (in_ready=0). There is no accept in the same cycle as the result leaves; the next accept is earliest the following cycle.
- Latency: accept edge E, out_valid high in the cycle after edge E+WIDTH. Maximum throughput is one operation per WIDTH+2 cycles.
- Outside DONE, out_data and out_ovf hold their last values; they are 0 after reset.
- in_data and in_abs are sampled only on the accept edge; later changes have no effect.

Decomposition:
- Shared include serial_twos_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default WIDTH/CNT_W
- The only sub-module is one existing full_adder instance (ports A, B, Cin, Y, Cout) holding the datapath bit.
- FSM, counter and shift registers live in serial_twos_ctrl itself.

Test Plan:
1. Negate: in_data=8'h05, in_abs=0 accepted at edge E -> out_valid rises after edge E+8; out_data=8'hFB, out_ovf=0; busy high throughout.
2. Most-negative value: in_data=8'h80, in_abs=0 -> out_data=8'h80, out_ovf=1. Repeat with in_abs=1 -> same result, out_ovf=1.
3. Abs: in_data=8'hF6, in_abs=1 -> 8'h0A, ovf 0. Then in_data=8'h33, in_abs=1 -> 8'h33 unchanged, ovf 0. Also 8'h00, in_abs=0 -> 8'h00, ovf 0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing in_data -> out_data stable, in_ready=0, no accept. Raise out_ready -> IDLE next cycle, then accept.
5. Reset mid-operation: rst_n=0 on the 4th SHIFT edge -> next cycle state IDLE, out_valid=0, out_data=0, in_ready=1. A following operation (8'h01 negate) yields 8'hFF with correct latency.
6. Back-to-back: in_valid held high, out_ready=1 continuously over operands 8'h01, 8'h7F, 8'hFF -> results 8'hFF, 8'h81, 8'h01. Accepts spaced exactly WIDTH+2 cycles apart.
